// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: frame state encoding,
// data width and the default bit period.
// Optional build macro: UART_TX_PARITY_EN adds an even-parity bit after DATA.
package uart_pkg;

    localparam int          DATA_BITS            = 8;
    localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;   // 100 MHz / 115200

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } tx_state_t;

endpackage

// File: rtl/uart_tx_serializer_baud_cnt.sv
// Bit-period counter for the UART transmitter. Counts clk cycles inside a
// serial bit, wraps at every bit boundary and is held at zero while
// i_restart is high.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_restart,
    output logic        o_bit_end,
    output logic [15:0] o_count
);

    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

    logic [15:0] r_count;

    // Count clocks within the current bit; clear on restart or at the boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_restart || (r_count == LAST_CNT)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 16'd1;
        end
    end

    assign o_bit_end = !i_restart && (r_count == LAST_CNT);
    assign o_count   = r_count;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops one byte from the TX FIFO and sends
// start bit, 8 data bits LSB first, optional parity, one stop bit.
// Optional build macro: UART_TX_PARITY_EN (even parity bit, 11-bit frame);
// without it the frame is 10 bits.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_dout,
    output logic       read_enable,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam logic [15:0] PRE_LAST_CNT = 16'(CLKS_PER_BIT - 2);
    localparam logic [2:0]  LAST_IDX     = 3'(DATA_BITS - 1);

    tx_state_t              r_state;
    logic                   r_tx;
    logic                   r_read_enable;
    logic                   r_busy;
    logic                   r_tx_done;
    logic [DATA_BITS-1:0]   r_shift;
    logic [2:0]             r_bit_idx;
`ifdef UART_TX_PARITY_EN
    logic                   r_parity;
`endif

    logic                   w_restart;
    logic                   w_bit_end;
    logic [15:0]            w_count;

    // Bit counter runs only while a bit is on the line; held clear before START
    assign w_restart = (r_state == ST_IDLE) || (r_state == ST_FETCH) ||
                       (r_state == ST_LOAD);

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk       (clk),
        .rst       (rst),
        .i_restart (w_restart),
        .o_bit_end (w_bit_end),
        .o_count   (w_count)
    );

    // Frame sequencer; every output register is updated on entry to the
    // state it belongs to, so outputs line up cycle-for-cycle with r_state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_tx          <= 1'b1;
            r_read_enable <= 1'b0;
            r_busy        <= 1'b0;
            r_tx_done     <= 1'b0;
            r_shift       <= '0;
            r_bit_idx     <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity      <= 1'b0;
`endif
        end else begin
            r_read_enable <= 1'b0;
            // Raised one clk early so the pulse sits on the last stop-bit clk
            r_tx_done     <= (r_state == ST_STOP) && (w_count == PRE_LAST_CNT);
            case (r_state)
                ST_IDLE: begin
                    if (tx_enable && !fifo_empty) begin
                        r_state       <= ST_FETCH;
                        r_read_enable <= 1'b1;
                        r_busy        <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_shift  <= fifo_dout;
`ifdef UART_TX_PARITY_EN
                    r_parity <= ^fifo_dout;
`endif
                    r_tx     <= 1'b0;
                    r_state  <= ST_START;
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_tx      <= r_shift[0];
                        r_bit_idx <= '0;
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                            r_tx    <= r_parity;
                            r_state <= ST_PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= ST_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_tx    <= 1'b1;
                        r_state <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_bit_end) begin
                        if (tx_enable && !fifo_empty) begin
                            r_state       <= ST_FETCH;
                            r_read_enable <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx          = r_tx;
    assign read_enable = r_read_enable;
    assign busy        = r_busy;
    assign tx_done     = r_tx_done;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer with CLKS_PER_BIT=4.
// A frame-timeline model predicts tx/read_enable/busy/tx_done every cycle;
// directed scenarios add hand-computed literal checks.
// Honours UART_TX_PARITY_EN the same way the design does.
module tb_uart_tx_serializer;

    localparam int N = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    // Positions in a transaction: 0 = fetch, 1 = load, 2.. = frame bits
    localparam int LAST = 2 + FB * N - 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_enable;
    logic       fifo_empty;
    logic [7:0] fifo_dout = 8'h00;
    logic       read_enable;
    logic       tx;
    logic       busy;
    logic       tx_done;

    always #5 clk = ~clk;

    uart_tx_serializer #(
        .CLKS_PER_BIT (N)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_enable   (tx_enable),
        .fifo_empty  (fifo_empty),
        .fifo_dout   (fifo_dout),
        .read_enable (read_enable),
        .tx          (tx),
        .busy        (busy),
        .tx_done     (tx_done)
    );

    // ---------------- FIFO environment ----------------
    logic [7:0] fifo_mem [0:15];
    int         wr_ptr = 0;
    int         rd_ptr = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (read_enable) begin
            fifo_dout <= fifo_mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;
    int re_cnt = 0;
    int done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (read_enable === 1'b1) re_cnt++;
        if (tx_done === 1'b1) done_cnt++;
    end

    // ---------------- reference model ----------------
    bit         m_active = 1'b0;
    int         m_pos    = 0;
    int         m_rd     = 0;
    logic [7:0] m_byte   = 8'h00;

    function automatic logic frame_bit(input int k, input logic [7:0] b);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0;
            m_pos    = 0;
        end else if (!m_active || m_pos == LAST) begin
            if (tx_enable && !fifo_empty) begin
                m_active = 1'b1;
                m_pos    = 0;
                m_byte   = fifo_mem[m_rd];
                m_rd     = m_rd + 1;
            end else begin
                m_active = 1'b0;
            end
        end else begin
            m_pos = m_pos + 1;
        end
    end

    logic [3:0] exp_v;

    // Per-cycle comparison of {tx, read_enable, busy, tx_done}
    always @(negedge clk) begin
        if (!rst) begin
            exp_v = 4'b1000;
            if (m_active) begin
                exp_v[3] = (m_pos < 2) ? 1'b1 : frame_bit((m_pos - 2) / N, m_byte);
                exp_v[2] = (m_pos == 0);
                exp_v[1] = 1'b1;
                exp_v[0] = (m_pos == LAST);
            end
            check("cycle_tx_rd_busy_done", {28'd0, tx, read_enable, busy, tx_done}, {28'd0, exp_v});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_re(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (read_enable === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("wait_read_enable_timeout", 32'd0, 32'd1);
    endtask

    bit            ok;
    int            base_re;
    int            base_done;
    logic [FB-1:0] got;
    logic [FB-1:0] exp_frame;
    logic          first;
    int            held_bad;
    int            res;
    int            dones;
    int            busy_low;
    int            gap;
    bit            counting;
    int            busy_hi;
    int            tx_low;

    initial begin
        rst       = 1'b1;
        tx_enable = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_read_enable", {31'd0, read_enable}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_tx_done", {31'd0, tx_done}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // ---- single frame, bit-level literal check ----
        base_re   = re_cnt;
        base_done = done_cnt;
`ifdef UART_TX_PARITY_EN
        push(8'h07);
        exp_frame = 11'b11000001110;
`else
        push(8'hA5);
        exp_frame = 10'b1101001010;
`endif
        tx_enable = 1'b1;
        wait_re(ok);
        if (ok) begin
            @(negedge clk);
            got      = '0;
            held_bad = 0;
            for (int i = 0; i < FB; i++) begin
                for (int j = 0; j < N; j++) begin
                    @(negedge clk);
                    if (j == 0) first = tx;
                    else if (tx !== first) held_bad++;
                end
                got[i] = first;
            end
            check("frame_bits", 32'(got), 32'(exp_frame));
            check("bit_hold_clks", held_bad, 0);
        end
        repeat (10) @(negedge clk);
        check("frame_read_pulses", re_cnt - base_re, 1);
        check("frame_done_pulses", done_cnt - base_done, 1);
        check("frame_busy_after", {31'd0, busy}, 32'd0);

        // ---- back-to-back frames ----
        base_re  = re_cnt;
        push(8'h55);
        push(8'hAA);
        res = 0; dones = 0; busy_low = 0; gap = 0; counting = 1'b0;
        for (int c = 0; c < 300 && dones < 2; c++) begin
            @(negedge clk);
            if (read_enable) res++;
            if (res >= 1 && !busy) busy_low++;
            if (tx_done) begin
                dones++;
                counting = (dones == 1);
            end else if (counting) begin
                if (tx) gap++;
                else counting = 1'b0;
            end
        end
        check("b2b_frames_done", dones, 2);
        check("b2b_mark_gap", gap, 2);
        check("b2b_busy_low_cycles", busy_low, 0);
        check("b2b_read_pulses", res, 2);
        repeat (5) @(negedge clk);

        // ---- empty FIFO, enabled ----
        base_re = re_cnt;
        busy_hi = 0;
        tx_low  = 0;
        repeat (100) begin
            @(negedge clk);
            if (busy) busy_hi++;
            if (!tx) tx_low++;
        end
        check("empty_read_pulses", re_cnt - base_re, 0);
        check("empty_busy_cycles", busy_hi, 0);
        check("empty_tx_low_cycles", tx_low, 0);

        // ---- tx_enable dropped during data bit 2 ----
        base_re   = re_cnt;
        base_done = done_cnt;
        push(8'h3C);
        push(8'h81);
        wait_re(ok);
        repeat (2 + 3 * N + 1) @(negedge clk);
        check("drop_busy_mid_frame", {31'd0, busy}, 32'd1);
        tx_enable = 1'b0;
        repeat (60) @(negedge clk);
        check("drop_read_pulses", re_cnt - base_re, 1);
        check("drop_done_pulses", done_cnt - base_done, 1);
        check("drop_busy_idle", {31'd0, busy}, 32'd0);
        check("drop_fifo_level", wr_ptr - rd_ptr, 1);
        tx_enable = 1'b1;
        repeat (60) @(negedge clk);
        check("resume_read_pulses", re_cnt - base_re, 2);
        check("resume_done_pulses", done_cnt - base_done, 2);

        // ---- asynchronous reset during data bit 3 of 0xFF ----
        base_re = re_cnt;
        push(8'hFF);
        wait_re(ok);
        repeat (2 + 4 * N + 1) @(negedge clk);
        check("rst_mid_busy_before", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_tx", {31'd0, tx}, 32'd1);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_read_enable", {31'd0, read_enable}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("rst_after_read_pulses", re_cnt - base_re, 1);
        check("rst_after_fifo_empty", {31'd0, fifo_empty}, 32'd1);
        check("rst_after_tx", {31'd0, tx}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
